// File: rtl/single_demux_buf_pkg.sv
// Shared definitions for the single-input, two-output demultiplexing buffer.
// Holds the width defaults, destination select encodings and slot state type.
package single_demux_buf_pkg;

    localparam int N_DEF  = 5;
    localparam int CW_DEF = 8;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/single_slot.sv
// One-entry output buffer with valid/ready handshake and a wrapping transfer counter.
// can_load tells the router whether a word offered this cycle would be taken.
module single_slot
    import single_demux_buf_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [N-1:0]  load_data,
    output logic          valid,
    input  logic          ready,
    output logic [N-1:0]  data,
    output logic [CW-1:0] cnt,
    output logic          can_load
);

    slot_state_e   state_reg;
    slot_state_e   state_next;
    logic [N-1:0]  data_reg;
    logic [CW-1:0] cnt_reg;
    logic          drain;

    assign drain = (state_reg == SLOT_FULL) && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= SLOT_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SLOT_EMPTY: if (load) state_next = SLOT_FULL;
            SLOT_FULL:  if (drain && !load) state_next = SLOT_EMPTY;
            default:    state_next = SLOT_EMPTY;
        endcase
    end

    always_comb begin
        valid    = (state_reg == SLOT_FULL);
        can_load = (state_reg == SLOT_EMPTY) || drain;
        data     = data_reg;
        cnt      = cnt_reg;
    end

    // The router only asserts load when can_load is high, so a load never
    // overwrites a word that is still waiting to be taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
        end else if (load) begin
            data_reg <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (drain) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/single_demux_buf.sv
// Routes each accepted input word to slot A or B according to in_sel.
// Only routing and in_ready live here; storage and counting are in single_slot.
module single_demux_buf
    import single_demux_buf_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_sel,
    output logic          a_valid,
    input  logic          a_ready,
    output logic [N-1:0]  a_data,
    output logic          b_valid,
    input  logic          b_ready,
    output logic [N-1:0]  b_data,
    output logic [CW-1:0] cnt_a,
    output logic [CW-1:0] cnt_b
);

    logic [1:0]    slot_load;
    logic [1:0]    slot_ready;
    logic [1:0]    slot_valid;
    logic [1:0]    slot_can;
    logic [N-1:0]  slot_data [2];
    logic [CW-1:0] slot_cnt  [2];
    logic          in_xfer;

    // in_ready looks only at the selected slot, so a stalled slot never
    // blocks traffic headed for the other one; reset forces it low.
    assign in_ready = rst_n && ((in_sel == SEL_B) ? slot_can[1] : slot_can[0]);
    assign in_xfer  = in_valid && in_ready;

    assign slot_load[0] = in_xfer && (in_sel == SEL_A);
    assign slot_load[1] = in_xfer && (in_sel == SEL_B);
    assign slot_ready   = {b_ready, a_ready};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            single_slot #(
                .N  (N),
                .CW (CW)
            ) u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (slot_load[gi]),
                .load_data (in_data),
                .valid     (slot_valid[gi]),
                .ready     (slot_ready[gi]),
                .data      (slot_data[gi]),
                .cnt       (slot_cnt[gi]),
                .can_load  (slot_can[gi])
            );
        end
    endgenerate

    assign a_valid = slot_valid[0];
    assign b_valid = slot_valid[1];
    assign a_data  = slot_data[0];
    assign b_data  = slot_data[1];
    assign cnt_a   = slot_cnt[0];
    assign cnt_b   = slot_cnt[1];

endmodule

// File: tb/tb_single_demux_buf.sv
// Directed plus random stimulus for single_demux_buf, checked against a
// queue-based model of two one-deep output buffers and their transfer counts.
module tb_single_demux_buf;

    localparam int N  = 5;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_data = '0;
    logic          in_sel = 1'b0;
    logic          a_valid;
    logic          a_ready = 1'b0;
    logic [N-1:0]  a_data;
    logic          b_valid;
    logic          b_ready = 1'b0;
    logic [N-1:0]  b_data;
    logic [CW-1:0] cnt_a;
    logic [CW-1:0] cnt_b;

    int errors = 0;
    int checks = 0;

    // Model: each output is a buffer holding at most one word.
    logic [N-1:0] qa[$];
    logic [N-1:0] qb[$];
    int           ma_cnt = 0;
    int           mb_cnt = 0;
    int           accepted;
    int           saved;

    single_demux_buf #(.N(N), .CW(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".a_valid"}, 32'(a_valid), 32'(qa.size() != 0));
        chk({tag, ".b_valid"}, 32'(b_valid), 32'(qb.size() != 0));
        if (qa.size() != 0) chk({tag, ".a_data"}, 32'(a_data), 32'(qa[0]));
        if (qb.size() != 0) chk({tag, ".b_data"}, 32'(b_data), 32'(qb[0]));
        chk({tag, ".cnt_a"}, 32'(cnt_a), 32'(ma_cnt % 256));
        chk({tag, ".cnt_b"}, 32'(cnt_b), 32'(mb_cnt % 256));
    endtask

    // One clock cycle: drive inputs, check in_ready, advance model and DUT, check outputs.
    task automatic cycle(input string tag, input logic v, input logic [N-1:0] d,
                         input logic s, input logic ar, input logic br);
        logic exp_rdy;
        logic acc;
        in_valid = v;
        in_data  = d;
        in_sel   = s;
        a_ready  = ar;
        b_ready  = br;
        #1;
        exp_rdy = s ? (qb.size() == 0 || br) : (qa.size() == 0 || ar);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        if (acc) accepted++;
        @(posedge clk);
        if (ar && qa.size() != 0) begin void'(qa.pop_front()); ma_cnt++; end
        if (br && qb.size() != 0) begin void'(qb.pop_front()); mb_cnt++; end
        if (acc) begin
            if (s) qb.push_back(d);
            else   qa.push_back(d);
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic check_reset_state(input string tag);
        in_valid = 1'b1;
        in_sel   = 1'b0;
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        #1;
        chk({tag, ".in_ready_a"}, 32'(in_ready), 32'(0));
        in_sel = 1'b1;
        #1;
        chk({tag, ".in_ready_b"}, 32'(in_ready), 32'(0));
        chk({tag, ".a_valid"}, 32'(a_valid), 32'(0));
        chk({tag, ".b_valid"}, 32'(b_valid), 32'(0));
        chk({tag, ".a_data"}, 32'(a_data), 32'(0));
        chk({tag, ".b_data"}, 32'(b_data), 32'(0));
        chk({tag, ".cnt_a"}, 32'(cnt_a), 32'(0));
        chk({tag, ".cnt_b"}, 32'(cnt_b), 32'(0));
    endtask

    initial begin
        // Power-on reset, released between clock edges.
        @(posedge clk);
        #1;
        check_reset_state("reset");
        qa.delete(); qb.delete(); ma_cnt = 0; mb_cnt = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Routing.
        cycle("route0", 1'b1, 5'h0A, 1'b0, 1'b1, 1'b1);
        chk("route0.a_data_0A", 32'(a_data), 32'h0A);
        cycle("route1", 1'b1, 5'h15, 1'b1, 1'b1, 1'b1);
        chk("route1.b_data_15", 32'(b_data), 32'h15);
        cycle("route2", 1'b0, 5'h00, 1'b0, 1'b1, 1'b1);
        chk("route2.cnt_a_1", 32'(cnt_a), 32'd1);
        chk("route2.cnt_b_1", 32'(cnt_b), 32'd1);

        // Backpressure on A.
        cycle("bp0", 1'b1, 5'h03, 1'b0, 1'b0, 1'b1);
        cycle("bp1", 1'b1, 5'h04, 1'b0, 1'b0, 1'b1);
        chk("bp1.a_data_hold_03", 32'(a_data), 32'h03);
        cycle("bp2", 1'b1, 5'h04, 1'b0, 1'b1, 1'b1);
        chk("bp2.a_data_04", 32'(a_data), 32'h04);
        cycle("bp3", 1'b0, 5'h00, 1'b0, 1'b1, 1'b1);

        // Isolation: A stalled full, B still accepts.
        cycle("iso0", 1'b1, 5'h05, 1'b0, 1'b0, 1'b1);
        cycle("iso1", 1'b1, 5'h1F, 1'b1, 1'b0, 1'b1);
        chk("iso1.b_valid", 32'(b_valid), 32'd1);
        chk("iso1.b_data_1F", 32'(b_data), 32'h1F);
        cycle("iso2", 1'b0, 5'h00, 1'b0, 1'b1, 1'b1);

        // Throughput: 32 back-to-back words to B.
        accepted = 0;
        saved = mb_cnt;
        for (int i = 0; i < 32; i++) begin
            cycle("thru", 1'b1, N'($urandom), 1'b1, 1'b1, 1'b1);
        end
        cycle("thru_end", 1'b0, 5'h00, 1'b1, 1'b1, 1'b1);
        chk("thru.accepted_32", 32'(accepted), 32'd32);
        chk("thru.cnt_b_delta_32", 32'((cnt_b - CW'(saved)) & 8'hFF), 32'd32);

        // Counter wrap: 256 transfers on A.
        saved = ma_cnt % 256;
        for (int i = 0; i < 256; i++) begin
            cycle("wrap", 1'b1, N'($urandom), 1'b0, 1'b1, 1'b1);
        end
        cycle("wrap_end", 1'b0, 5'h00, 1'b0, 1'b1, 1'b1);
        chk("wrap.cnt_a_back", 32'(cnt_a), 32'(saved));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom), N'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
        end

        // Mid-operation reset with both slots full.
        cycle("mid0", 1'b1, 5'h0C, 1'b0, 1'b0, 1'b0);
        cycle("mid1", 1'b1, 5'h13, 1'b1, 1'b0, 1'b0);
        chk("mid1.both_full", 32'({a_valid, b_valid}), 32'b11);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        qa.delete(); qb.delete(); ma_cnt = 0; mb_cnt = 0;
        in_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle("post0", 1'b1, 5'h11, 1'b0, 1'b1, 1'b1);
        chk("post0.a_data_11", 32'(a_data), 32'h11);
        cycle("post1", 1'b0, 5'h00, 1'b0, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
